classifier_arbiter: RTL and testbench

Shares a single `packet_classifier` instance between `NUM_SRC` packet sources. Round-robin arbitration selects one pending packet descriptor at a time and issues it to the classifier using the classifier's `in_ready`/`in_wr` handshake. A tag FIFO records the issuing source of each descriptor, so each in-order `out_flow_class` result is routed back to the source that sent it. The block sits between the per-port flow extractors and the classifier.

---
 rtl/classifier_arbiter_if.sv | 24 ++
 rtl/classifier_arbiter.sv | 128 ++++++++++++
 tb/tb_classifier_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/classifier_arbiter_if.sv
// classifier_arbiter_if: descriptor/result bus between the arbiter and the packet classifier
`ifndef FLOW_ID_WIDTH
`define FLOW_ID_WIDTH 16
`endif
`ifndef PKT_LENGTH_WIDTH
`define PKT_LENGTH_WIDTH 16
`endif
`ifndef FLOW_CLASS_WIDTH
`define FLOW_CLASS_WIDTH 4
`endif
interface classifier_arbiter_if #(
  parameter int FID_W = `FLOW_ID_WIDTH,
  parameter int LEN_W = `PKT_LENGTH_WIDTH,
  parameter int CLS_W = `FLOW_CLASS_WIDTH
);
  logic [FID_W-1:0] in_flow_id;
  logic [LEN_W-1:0] in_length;
  logic             in_wr;
  logic             in_ready;
  logic [CLS_W-1:0] out_class;
  logic             out_wr;
  modport master (output in_flow_id, in_length, in_wr, input in_ready, out_class, out_wr);
  modport slave  (input in_flow_id, in_length, in_wr, output in_ready, out_class, out_wr);
endinterface

// File: rtl/classifier_arbiter.sv
// classifier_arbiter: round-robin sharing of one packet classifier with in-order result routing
`ifndef FLOW_ID_WIDTH
`define FLOW_ID_WIDTH 16
`endif
`ifndef PKT_LENGTH_WIDTH
`define PKT_LENGTH_WIDTH 16
`endif
`ifndef FLOW_CLASS_WIDTH
`define FLOW_CLASS_WIDTH 4
`endif
module classifier_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int SRC_W     = 2,
  parameter int FID_W     = `FLOW_ID_WIDTH,
  parameter int LEN_W     = `PKT_LENGTH_WIDTH,
  parameter int CLS_W     = `FLOW_CLASS_WIDTH,
  parameter int TAG_DEPTH = 8,
  localparam int PTR_W    = $clog2(TAG_DEPTH),
  localparam int CNT_W    = $clog2(TAG_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SRC-1:0]       src_valid,
  input  logic [NUM_SRC*FID_W-1:0] src_flow_id,
  input  logic [NUM_SRC*LEN_W-1:0] src_length,
  output logic [NUM_SRC-1:0]       src_ack,
  classifier_arbiter_if.master     cls,
  output logic [NUM_SRC-1:0]       res_wr,
  output logic [CLS_W-1:0]         res_class,
  output logic [CNT_W-1:0]         outstanding,
  output logic                     err_orphan
);
  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE} state_t;
  state_t state_q, state_d;
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d, win;
  logic [FID_W-1:0] fid_q, fid_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic wr_q, wr_d;
  logic [NUM_SRC-1:0] ack_q, ack_d, res_wr_q, res_wr_d;
  logic [CLS_W-1:0] res_class_q, res_class_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] wp_q, wp_d, rp_q, rp_d;
  logic err_q, err_d;
  logic [SRC_W-1:0] tag_q [TAG_DEPTH];
  logic found, grant, push, pop;

  function automatic logic [SRC_W-1:0] step(input logic [SRC_W-1:0] p, input int i);
    int s;
    s = int'(p) + i;
    return SRC_W'(s >= NUM_SRC ? s - NUM_SRC : s);
  endfunction

  // first valid source scanning upward from the source after the last winner
  always_comb begin
    win = rr_ptr_q;
    found = 1'b0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      if (!found && src_valid[step(rr_ptr_q, i)]) begin
        win = step(rr_ptr_q, i);
        found = 1'b1;
      end
    end
  end

  // next-state, issue registers, tag FIFO bookkeeping and result routing
  always_comb begin
    grant = state_q == IDLE && cls.in_ready && |src_valid && cnt_q < CNT_W'(TAG_DEPTH);
    push = state_q == ISSUE;
    pop = cls.out_wr && cnt_q != '0;
    state_d = grant ? ISSUE : state_q == ISSUE ? SETTLE : state_q == SETTLE ? IDLE : state_q;
    rr_ptr_d = grant ? win : rr_ptr_q;
    fid_d = grant ? src_flow_id[win*FID_W +: FID_W] : fid_q;
    len_d = grant ? src_length[win*LEN_W +: LEN_W] : len_q;
    wr_d = grant;
    ack_d = grant ? NUM_SRC'(1) << win : '0;
    res_wr_d = pop ? NUM_SRC'(1) << tag_q[rp_q] : '0;
    res_class_d = pop ? cls.out_class : res_class_q;
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    wp_d = wp_q + PTR_W'(push);
    rp_d = rp_q + PTR_W'(pop);
    err_d = err_q | (cls.out_wr && cnt_q == '0);
  end

  // state and output registers; rr_ptr starts at the last source so source 0 wins first
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rr_ptr_q <= SRC_W'(NUM_SRC - 1);
      fid_q <= '0;
      len_q <= '0;
      wr_q <= 1'b0;
      ack_q <= '0;
      res_wr_q <= '0;
      res_class_q <= '0;
      cnt_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      fid_q <= fid_d;
      len_q <= len_d;
      wr_q <= wr_d;
      ack_q <= ack_d;
      res_wr_q <= res_wr_d;
      res_class_q <= res_class_d;
      cnt_q <= cnt_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      err_q <= err_d;
    end
  end

  // tag storage; during ISSUE rr_ptr holds the index of the source being issued
  always_ff @(posedge clk) begin
    if (push) tag_q[wp_q] <= rr_ptr_q;
  end

  assign src_ack = ack_q;
  assign cls.in_flow_id = fid_q;
  assign cls.in_length = len_q;
  assign cls.in_wr = wr_q;
  assign res_wr = res_wr_q;
  assign res_class = res_class_q;
  assign outstanding = cnt_q;
  assign err_orphan = err_q;
endmodule

// File: tb/tb_classifier_arbiter.sv
// tb_classifier_arbiter: directed checks of arbitration, tag routing, full/orphan/reset behaviour
module tb_classifier_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] src_valid;
  logic [63:0] src_flow_id, src_length;
  logic [3:0] src_ack, res_wr, res_class, outstanding;
  logic err_orphan;
  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt;

  classifier_arbiter_if #(.FID_W(16), .LEN_W(16), .CLS_W(4)) cls_if ();

  classifier_arbiter #(
    .NUM_SRC(4), .SRC_W(2), .FID_W(16), .LEN_W(16), .CLS_W(4), .TAG_DEPTH(8)
  ) dut (
    .clk(clk), .reset(reset), .src_valid(src_valid), .src_flow_id(src_flow_id),
    .src_length(src_length), .src_ack(src_ack), .cls(cls_if.master), .res_wr(res_wr),
    .res_class(res_class), .outstanding(outstanding), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    src_valid = '0;
    cls_if.in_ready = 1'b1;
    cls_if.out_wr = 1'b0;
    cls_if.out_class = '0;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic set_srcs;
    for (int i = 0; i < 4; i++) begin
      src_flow_id[i*16 +: 16] = 16'(32'h20 + i);
      src_length[i*16 +: 16] = 16'(10 + i);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    set_srcs;
    do_reset;
    chk("rst_ack", 32'(src_ack), 0);
    chk("rst_res_wr", 32'(res_wr), 0);
    chk("rst_in_wr", 32'(cls_if.in_wr), 0);
    chk("rst_orphan", 32'(err_orphan), 0);
    chk("rst_fid", 32'(cls_if.in_flow_id), 0);
    chk("rst_len", 32'(cls_if.in_length), 0);
    chk("rst_res_class", 32'(res_class), 0);
    chk("rst_outstanding", 32'(outstanding), 0);

    src_flow_id[15:0] = 16'h12;
    src_length[15:0] = 16'd64;
    src_valid = 4'b0001;
    tick;
    chk("single_wr", 32'(cls_if.in_wr), 1);
    chk("single_ack", 32'(src_ack), 32'h1);
    chk("single_fid", 32'(cls_if.in_flow_id), 32'h12);
    chk("single_len", 32'(cls_if.in_length), 64);
    src_valid = '0;
    tick;
    chk("single_wr_off", 32'(cls_if.in_wr), 0);
    chk("single_ack_off", 32'(src_ack), 0);
    chk("single_out1", 32'(outstanding), 1);
    chk("single_fid_hold", 32'(cls_if.in_flow_id), 32'h12);
    tick;
    cls_if.out_wr = 1'b1;
    cls_if.out_class = 4'd3;
    tick;
    cls_if.out_wr = 1'b0;
    chk("single_res_wr", 32'(res_wr), 32'h1);
    chk("single_res_class", 32'(res_class), 3);
    chk("single_out0", 32'(outstanding), 0);
    tick;
    chk("single_res_wr_off", 32'(res_wr), 0);

    set_srcs;
    do_reset;
    src_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("rr_wr", 32'(cls_if.in_wr), 1);
      chk("rr_ack", 32'(src_ack), 32'(1 << (k % 4)));
      chk("rr_fid", 32'(cls_if.in_flow_id), 32'(32'h20 + k % 4));
      chk("rr_len", 32'(cls_if.in_length), 32'(10 + k % 4));
      if (k == 4) src_valid = '0;
      tick;
      chk("rr_gap1", 32'(cls_if.in_wr), 0);
      tick;
      chk("rr_gap2", 32'(cls_if.in_wr), 0);
    end
    chk("rr_out5", 32'(outstanding), 5);
    cls_if.out_wr = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cls_if.out_class = 4'(k + 1);
      tick;
      chk("rr_res_wr", 32'(res_wr), 32'(1 << (k % 4)));
      chk("rr_res_class", 32'(res_class), 32'(k + 1));
    end
    cls_if.out_wr = 1'b0;
    chk("rr_out0", 32'(outstanding), 0);

    do_reset;
    src_valid = 4'b1111;
    wr_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      tick;
      if (cls_if.in_wr) wr_cnt++;
    end
    chk("full_issues", 32'(wr_cnt), 8);
    chk("full_out8", 32'(outstanding), 8);
    chk("full_no_wr", 32'(cls_if.in_wr), 0);
    cls_if.out_wr = 1'b1;
    cls_if.out_class = 4'd7;
    tick;
    cls_if.out_wr = 1'b0;
    chk("full_res_wr", 32'(res_wr), 32'h1);
    chk("full_out7", 32'(outstanding), 7);
    chk("full_hold_wr", 32'(cls_if.in_wr), 0);
    tick;
    chk("full_resume_wr", 32'(cls_if.in_wr), 1);
    chk("full_resume_ack", 32'(src_ack), 32'h1);
    src_valid = '0;
    tick;
    chk("full_refill", 32'(outstanding), 8);

    do_reset;
    src_valid = 4'b1111;
    for (int k = 0; k < 16; k++) tick;
    chk("sim_wr", 32'(cls_if.in_wr), 1);
    chk("sim_ack", 32'(src_ack), 32'h2);
    chk("sim_out5", 32'(outstanding), 5);
    src_valid = '0;
    cls_if.out_wr = 1'b1;
    cls_if.out_class = 4'd9;
    tick;
    cls_if.out_wr = 1'b0;
    chk("sim_out_same", 32'(outstanding), 5);
    chk("sim_res_wr", 32'(res_wr), 32'h1);
    chk("sim_res_class", 32'(res_class), 9);

    do_reset;
    cls_if.out_wr = 1'b1;
    cls_if.out_class = 4'd5;
    tick;
    cls_if.out_wr = 1'b0;
    chk("orphan_set", 32'(err_orphan), 1);
    chk("orphan_no_res", 32'(res_wr), 0);
    chk("orphan_out0", 32'(outstanding), 0);
    tick;
    tick;
    chk("orphan_sticky", 32'(err_orphan), 1);
    chk("orphan_no_res2", 32'(res_wr), 0);

    do_reset;
    chk("orphan_cleared", 32'(err_orphan), 0);
    src_valid = 4'b1111;
    for (int k = 0; k < 10; k++) tick;
    chk("mid_wr", 32'(cls_if.in_wr), 1);
    chk("mid_ack", 32'(src_ack), 32'h8);
    chk("mid_out3", 32'(outstanding), 3);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("mid_rst_wr", 32'(cls_if.in_wr), 0);
    chk("mid_rst_ack", 32'(src_ack), 0);
    chk("mid_rst_res", 32'(res_wr), 0);
    chk("mid_rst_fid", 32'(cls_if.in_flow_id), 0);
    chk("mid_rst_out", 32'(outstanding), 0);
    tick;
    chk("mid_regrant_wr", 32'(cls_if.in_wr), 1);
    chk("mid_regrant_ack", 32'(src_ack), 32'h1);
    chk("mid_regrant_fid", 32'(cls_if.in_flow_id), 32'h20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
